eth_pfc_pause_ctrl: RTL and testbench
=====================================

Name: eth_pfc_pause_ctrl

Overview:
Per-priority pause scheduler for the 8-priority PFC transmit FIFO stage and its trailing link-level FIFO. Decoded received PFC (802.1Qbb) and LFC (802.3x) pause requests go in. Nine quanta timers turn them into the 9-bit pause_req vector consumed by the TX FIFOs. Acknowledged pause state is reported back for status and flow-control accounting.

Parameters:
DATA_WIDTH, 64, datapath width in bits; sets the quantum prescale; power of 2, 8..512
QUANTA_BITS, 512, bit times per pause quantum (IEEE fixed)
TICK_CYCLES, QUANTA_BITS/DATA_WIDTH, clk cycles per quantum tick (derived localparam; 1 when DATA_WIDTH=512)

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous, active-low reset
rx_pfc_valid  in  1  one-cycle strobe: decoded PFC frame accepted
rx_pfc_en  in  8  priority-enable vector from the PFC frame
rx_pfc_quanta  in  128  per-priority quanta; priority i at [16*i+:16]
rx_lfc_valid  in  1  one-cycle strobe: decoded 802.3x pause frame accepted
rx_lfc_quanta  in  16  LFC pause quanta
cfg_pfc_en  in  1  1 = honour PFC frames
cfg_lfc_en  in  1  1 = honour LFC frames
cfg_force_pause  in  9  software force-pause per channel (bit 8 = LFC)
pause_req  out  9  to TX FIFOs; bits 0-7 = priorities, bit 8 = link FIFO
pause_ack  in  9  from TX FIFOs
pause_active  out  9  pause_req & pause_ack, registered
busy  out  1  any timer nonzero

Behaviour:
- Reset (rst_n=0 at a clk edge): all timers=0, prescaler=0. pause_req, pause_active and busy = 0.
- Prescaler:
  - Free-running counter 0..TICK_CYCLES-1.
  - tick asserts for one cycle on wrap.
  - With TICK_CYCLES=1, tick is high every cycle.
  - Shared across all timers, so actual pause may be up to one quantum short.
- Timer i (0-7):
  - Load: when rx_pfc_valid & cfg_pfc_en & rx_pfc_en[i], timer[i] <= rx_pfc_quanta[i] (16-bit).
  - The load overwrites the current value, lower or higher.
  - Quanta 0 clears the timer, i.e. immediate XON.
- Timer 8: same rule, loaded from rx_lfc_quanta when rx_lfc_valid & cfg_lfc_en.
- Decrement: on tick, a nonzero timer decrements by 1. It never wraps below 0.
- Simultaneous load and tick on the same timer: the load wins and no decrement happens that cycle.
- rx_pfc_valid and rx_lfc_valid in the same cycle are independent; both apply.
- cfg_*_en deasserting does not clear running timers; they expire naturally.
- pause_req[i] (registered) = (timer[i] != 0) | cfg_force_pause[i].
  - Latency: load at edge N gives pause_req high after edge N+1.
  - With q quanta loaded, pause_req stays high for q ticks (±1 tick of prescaler phase), then drops the cycle after the timer reaches 0.
- pause_active: registered AND of pause_req and pause_ack; 1 cycle behind the inputs.
  - The FIFOs only acknowledge at a frame boundary, so pause_active may lag pause_req by a whole frame.
  - If pause_req drops before ack arrives, pause_active stays 0.
- busy: registered OR of (timer != 0) over all 9 timers; excludes force.
- Reset mid-pause: all outputs go low on the next edge. pause_req to the FIFOs releases immediately.

Optional Feature:
ETH_PFC_PAUSE_STATS_EN
- Defined: adds output stat_pause_cnt [143:0], nine 16-bit saturating counters (channel i at [16*i+:16]).
  - Counter i increments on each accepted load with nonzero quanta for channel i.
  - It saturates at 0xFFFF and clears only on reset.
  - Adds input stat_clr [1], a one-cycle strobe that zeroes all counters; stat_clr wins over a same-cycle increment.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan:
1. DATA_WIDTH=64 (TICK_CYCLES=8), cfg_pfc_en=1; PFC with rx_pfc_en=0x04, quanta[2]=10 -> pause_req=0x004 one cycle later, held 80±8 cycles, then 0; busy tracks it.
2. Priority 5 running with 100 quanta; new PFC with quanta[5]=0 -> pause_req[5] falls the cycle after the load (XON).
3. Same-cycle LFC quanta=3 and PFC en=0x81 quanta=2 -> pause_req=0x181. Bits 0 and 7 clear about 8 cycles before bit 8.
4. cfg_pfc_en=0, PFC en=0xFF -> pause_req stays 0. cfg_force_pause=0x010 -> pause_req[4]=1, busy=0.
5. pause_ack[3] delayed 20 cycles after pause_req[3] -> pause_active[3] rises exactly 1 cycle after ack. rst_n=0 mid-pause -> all outputs 0 next edge.
6. (STATS_EN) 70000 loads on channel 1 -> stat_pause_cnt[31:16]=0xFFFF. Quanta-0 loads do not count. stat_clr -> all counters 0.

Source files
------------

// File: rtl/eth_pfc_pause_ctrl.sv
// PFC/LFC pause scheduler: nine quanta timers driving the 9-bit pause_req vector to the TX FIFOs.
// Optional per-channel pause counters with ETH_PFC_PAUSE_STATS_EN.

module eth_pfc_pause_chan (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] quanta,
  input  logic        force_pause,
  input  logic        ack,
`ifdef ETH_PFC_PAUSE_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_cnt,
`endif
  output logic        timer_nz,
  output logic        req,
  output logic        active
);
  logic [15:0] timer;

  assign timer_nz = (timer != 16'd0);

  // A load in the same cycle as a tick wins; the tick is simply lost for that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer  <= '0;
      req    <= 1'b0;
      active <= 1'b0;
    end else begin
      if (load)                  timer <= quanta;
      else if (tick && timer_nz) timer <= timer - 16'd1;
      req    <= timer_nz | force_pause;
      active <= req & ack;
    end
  end

`ifdef ETH_PFC_PAUSE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr)
      stat_cnt <= '0;
    else if (load && quanta != 16'd0 && stat_cnt != 16'hFFFF)
      stat_cnt <= stat_cnt + 16'd1;
  end
`endif
endmodule

module eth_pfc_pause_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int QUANTA_BITS = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_pfc_valid,
  input  logic [7:0]   rx_pfc_en,
  input  logic [127:0] rx_pfc_quanta,
  input  logic         rx_lfc_valid,
  input  logic [15:0]  rx_lfc_quanta,
  input  logic         cfg_pfc_en,
  input  logic         cfg_lfc_en,
  input  logic [8:0]   cfg_force_pause,
  output logic [8:0]   pause_req,
  input  logic [8:0]   pause_ack,
  output logic [8:0]   pause_active,
`ifdef ETH_PFC_PAUSE_STATS_EN
  input  logic         stat_clr,
  output logic [143:0] stat_pause_cnt,
`endif
  output logic         busy
);
  localparam int NUM_CH      = 9;
  localparam int TICK_CYCLES = QUANTA_BITS / DATA_WIDTH;
  localparam int PW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0]              pre;
  logic                       tick;
  logic [NUM_CH-1:0]          load;
  logic [NUM_CH-1:0][15:0]    quanta;
  logic [NUM_CH-1:0]          timer_nz;
`ifdef ETH_PFC_PAUSE_STATS_EN
  logic [NUM_CH-1:0][15:0]    cnt;
  assign stat_pause_cnt = cnt;
`endif

  // One prescaler shared by all timers: a pause can end up to one quantum short.
  assign tick = (pre == PW'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre  <= '0;
      busy <= 1'b0;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      busy <= |timer_nz;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (i < 8) begin : g_pfc
      assign load[i]   = rx_pfc_valid & cfg_pfc_en & rx_pfc_en[i];
      assign quanta[i] = rx_pfc_quanta[16*i +: 16];
    end else begin : g_lfc
      assign load[i]   = rx_lfc_valid & cfg_lfc_en;
      assign quanta[i] = rx_lfc_quanta;
    end

    eth_pfc_pause_chan u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .load        (load[i]),
      .quanta      (quanta[i]),
      .force_pause (cfg_force_pause[i]),
      .ack         (pause_ack[i]),
`ifdef ETH_PFC_PAUSE_STATS_EN
      .stat_clr    (stat_clr),
      .stat_cnt    (cnt[i]),
`endif
      .timer_nz    (timer_nz[i]),
      .req         (pause_req[i]),
      .active      (pause_active[i])
    );
  end
endmodule

// File: tb/tb_eth_pfc_pause_ctrl.sv
// Directed vector bench for eth_pfc_pause_ctrl at DATA_WIDTH=64 (tick every 8 cycles).
module tb_eth_pfc_pause_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_pfc_valid;
  logic [7:0]   rx_pfc_en;
  logic [127:0] rx_pfc_quanta;
  logic         rx_lfc_valid;
  logic [15:0]  rx_lfc_quanta;
  logic         cfg_pfc_en, cfg_lfc_en;
  logic [8:0]   cfg_force_pause;
  logic [8:0]   pause_req, pause_ack, pause_active;
  logic         busy;
`ifdef ETH_PFC_PAUSE_STATS_EN
  logic         stat_clr;
  logic [143:0] stat_pause_cnt;
`endif

  always #5 clk = ~clk;

  eth_pfc_pause_ctrl #(.DATA_WIDTH(64), .QUANTA_BITS(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_pfc_valid(rx_pfc_valid), .rx_pfc_en(rx_pfc_en), .rx_pfc_quanta(rx_pfc_quanta),
    .rx_lfc_valid(rx_lfc_valid), .rx_lfc_quanta(rx_lfc_quanta),
    .cfg_pfc_en(cfg_pfc_en), .cfg_lfc_en(cfg_lfc_en), .cfg_force_pause(cfg_force_pause),
    .pause_req(pause_req), .pause_ack(pause_ack), .pause_active(pause_active),
`ifdef ETH_PFC_PAUSE_STATS_EN
    .stat_clr(stat_clr), .stat_pause_cnt(stat_pause_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    logic        pv;
    logic [7:0]  pen;
    logic [15:0] pq;
    logic        lv;
    logic [15:0] lq;
    logic        cp, cl;
    logic [8:0]  frc, ack;
    int          n;      // check after this many edges following reset release
    logic [8:0]  er, ea;
    logic        eb;
  } vec_t;

  localparam int NV = 20;
  vec_t vt[NV];
  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rx_pfc_valid = 0; rx_pfc_en = '0; rx_pfc_quanta = '0;
    rx_lfc_valid = 0; rx_lfc_quanta = '0;
    cfg_pfc_en = 0; cfg_lfc_en = 0; cfg_force_pause = '0; pause_ack = '0;
`ifdef ETH_PFC_PAUSE_STATS_EN
    stat_clr = 0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic pfc(input logic [7:0] en, input logic [15:0] q);
    rx_pfc_valid = 1; rx_pfc_en = en; rx_pfc_quanta = {8{q}};
  endtask

  task automatic step(input int k);
    for (int j = 0; j < k; j++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    //        pv  pen    pq  lv  lq cp cl frc     ack     n   er      ea      eb
    vt[0]  = '{0, 8'h00, 0,  0, 0, 1, 1, 9'h000, 9'h000, 1,  9'h000, 9'h000, 0};
    vt[1]  = '{1, 8'h04, 10, 0, 0, 1, 0, 9'h000, 9'h000, 1,  9'h000, 9'h000, 0};
    vt[2]  = '{1, 8'h04, 10, 0, 0, 1, 0, 9'h000, 9'h000, 2,  9'h004, 9'h000, 1};
    vt[3]  = '{1, 8'h04, 10, 0, 0, 1, 0, 9'h000, 9'h000, 80, 9'h004, 9'h000, 1};
    vt[4]  = '{1, 8'h04, 10, 0, 0, 1, 0, 9'h000, 9'h000, 81, 9'h000, 9'h000, 0};
    vt[5]  = '{1, 8'hFF, 5,  0, 0, 0, 0, 9'h000, 9'h000, 3,  9'h000, 9'h000, 0};
    vt[6]  = '{1, 8'hFF, 5,  0, 0, 0, 0, 9'h010, 9'h000, 3,  9'h010, 9'h000, 0};
    vt[7]  = '{1, 8'h81, 2,  1, 3, 1, 1, 9'h000, 9'h000, 2,  9'h181, 9'h000, 1};
    vt[8]  = '{1, 8'h81, 2,  1, 3, 1, 1, 9'h000, 9'h000, 16, 9'h181, 9'h000, 1};
    vt[9]  = '{1, 8'h81, 2,  1, 3, 1, 1, 9'h000, 9'h000, 17, 9'h100, 9'h000, 1};
    vt[10] = '{1, 8'h81, 2,  1, 3, 1, 1, 9'h000, 9'h000, 24, 9'h100, 9'h000, 1};
    vt[11] = '{1, 8'h81, 2,  1, 3, 1, 1, 9'h000, 9'h000, 25, 9'h000, 9'h000, 0};
    vt[12] = '{1, 8'h08, 4,  0, 0, 1, 0, 9'h000, 9'h1FF, 2,  9'h008, 9'h000, 1};
    vt[13] = '{1, 8'h08, 4,  0, 0, 1, 0, 9'h000, 9'h1FF, 3,  9'h008, 9'h008, 1};
    vt[14] = '{1, 8'h08, 4,  0, 0, 1, 0, 9'h000, 9'h1FF, 33, 9'h000, 9'h008, 0};
    vt[15] = '{1, 8'h08, 4,  0, 0, 1, 0, 9'h000, 9'h1FF, 34, 9'h000, 9'h000, 0};
    vt[16] = '{0, 8'h00, 0,  1, 5, 1, 0, 9'h000, 9'h000, 2,  9'h000, 9'h000, 0};
    vt[17] = '{1, 8'hFF, 0,  0, 0, 1, 0, 9'h000, 9'h000, 2,  9'h000, 9'h000, 0};
    vt[18] = '{0, 8'h00, 0,  1, 1, 0, 1, 9'h000, 9'h100, 2,  9'h100, 9'h000, 1};
    vt[19] = '{0, 8'h00, 0,  1, 1, 0, 1, 9'h000, 9'h100, 3,  9'h100, 9'h100, 1};

    // Reset dominates active strobes and force.
    clear_inputs();
    rst_n = 0;
    cfg_pfc_en = 1; cfg_force_pause = 9'h1FF; pause_ack = 9'h1FF; pfc(8'hFF, 16'd7);
    step(2);
    check("rst_req", 16'(pause_req), 16'h0);
    check("rst_active", 16'(pause_active), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      cfg_pfc_en = vt[v].cp; cfg_lfc_en = vt[v].cl;
      cfg_force_pause = vt[v].frc; pause_ack = vt[v].ack;
      rx_pfc_valid = vt[v].pv; rx_pfc_en = vt[v].pen; rx_pfc_quanta = {8{vt[v].pq}};
      rx_lfc_valid = vt[v].lv; rx_lfc_quanta = vt[v].lq;
      @(posedge clk); #1;
      rx_pfc_valid = 0; rx_lfc_valid = 0;
      step(vt[v].n - 1);
      check($sformatf("v%0d_req", v), 16'(pause_req), 16'(vt[v].er));
      check($sformatf("v%0d_active", v), 16'(pause_active), 16'(vt[v].ea));
      check($sformatf("v%0d_busy", v), 16'(busy), 16'(vt[v].eb));
    end

    // XON: quanta 0 on a running priority releases it one cycle after the load.
    do_reset();
    cfg_pfc_en = 1; pfc(8'h20, 16'd100);
    step(1); rx_pfc_valid = 0;
    step(9);
    check("xon_running", 16'(pause_req), 16'h020);
    pfc(8'h20, 16'd0);
    step(1); rx_pfc_valid = 0;
    check("xon_load_edge", 16'(pause_req), 16'h020);
    step(1);
    check("xon_released", 16'(pause_req), 16'h000);
    check("xon_busy", 16'(busy), 16'h0);

    // Reload on a tick edge must not also decrement.
    do_reset();
    cfg_pfc_en = 1; pfc(8'h01, 16'd1);
    step(1); rx_pfc_valid = 0;
    step(6);
    pfc(8'h01, 16'd1);
    step(1); rx_pfc_valid = 0;
    step(8);
    check("load_vs_tick_hold", 16'(pause_req), 16'h001);
    step(1);
    check("load_vs_tick_drop", 16'(pause_req), 16'h000);

    // Disabling PFC does not cancel a running timer.
    do_reset();
    cfg_pfc_en = 1; pfc(8'h02, 16'd2);
    step(1); rx_pfc_valid = 0; cfg_pfc_en = 0;
    step(9);
    check("cfg_off_keeps", 16'(pause_req), 16'h002);

    // Delayed ack, then reset in the middle of a pause.
    do_reset();
    cfg_pfc_en = 1; pfc(8'h08, 16'd50);
    step(1); rx_pfc_valid = 0;
    step(21);
    check("ack_wait_req", 16'(pause_req), 16'h008);
    check("ack_wait_active", 16'(pause_active), 16'h000);
    pause_ack = 9'h008;
    step(1);
    check("ack_active", 16'(pause_active), 16'h008);
    rst_n = 0;
    step(1);
    check("midrst_req", 16'(pause_req), 16'h000);
    check("midrst_active", 16'(pause_active), 16'h000);
    check("midrst_busy", 16'(busy), 16'h0);
    rst_n = 1;

`ifdef ETH_PFC_PAUSE_STATS_EN
    do_reset();
    cfg_pfc_en = 1; pfc(8'h02, 16'd1);
    step(70000);
    check("stat_sat", stat_pause_cnt[31:16], 16'hFFFF);
    check("stat_other", stat_pause_cnt[15:0], 16'h0000);
    stat_clr = 1;
    step(1);
    stat_clr = 0; rx_pfc_valid = 0;
    check("stat_clr", stat_pause_cnt[31:16], 16'h0000);
    pfc(8'h02, 16'd0);
    step(3);
    pfc(8'h02, 16'd5);
    step(2);
    rx_pfc_valid = 0;
    check("stat_nonzero_only", stat_pause_cnt[31:16], 16'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
